// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - mode codes and shared result/accumulator computation
package addsub_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_CLR = 2'b11;

  // Wide enough for any practical WIDTH; callers truncate to WIDTH+1 bits,
  // which yields the required mod 2^(WIDTH+1) behaviour for SUB and ACC.
  localparam int CALC_W = 64;

  typedef struct packed {
    logic [CALC_W-1:0] res;
    logic [CALC_W-1:0] acc;
  } calc_t;

  function automatic calc_t addsub_calc(
    input logic [1:0]        mode,
    input logic [CALC_W-1:0] a,
    input logic [CALC_W-1:0] b,
    input logic [CALC_W-1:0] acc
  );
    calc_t r;
    r.res = '0;
    r.acc = acc;
    case (mode)
      MODE_ADD: r.res = a + b;
      MODE_SUB: r.res = a - b;
      MODE_ACC: begin
        r.acc = acc + a + b;
        r.res = r.acc;
      end
      default: r.acc = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/data pipeline register with a shared shift enable
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (en_i) begin
      valid_d = valid_i;
      data_d  = valid_i ? data_i : '0;  // bubbles carry zero data
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_addsub_acc.sv
// rtl/pipe_addsub_acc.sv - LAT-stage add/sub/accumulate pipeline with valid/ready on both sides
module pipe_addsub_acc
  import addsub_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out
);

  localparam int DW = WIDTH + 1;

  logic                 adv;
  logic                 accept;
  logic [LAT:0]         stg_valid;
  logic [LAT:0][DW-1:0] stg_data;
  logic [DW-1:0]        acc_q, acc_d;
  calc_t                calc;
  logic                 unused_calc_hi;

  // Whole pipeline moves or holds as one; a full last stage blocks everything.
  assign adv      = !stg_valid[LAT] || out_ready;
  assign accept   = in_valid && adv;
  assign in_ready = adv;

  assign calc = addsub_calc(in_mode, CALC_W'(in_a), CALC_W'(in_b), CALC_W'(acc_q));
  assign unused_calc_hi = ^{calc.res[CALC_W-1:DW], calc.acc[CALC_W-1:DW]};

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = calc.acc[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = calc.res[DW-1:0];

  for (genvar i = 1; i <= LAT; i++) begin : g_stage
    pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (adv),
      .valid_i(stg_valid[i-1]),
      .data_i (stg_data[i-1]),
      .valid_o(stg_valid[i]),
      .data_o (stg_data[i])
    );
  end

  assign out_valid = stg_valid[LAT];
  assign out       = stg_data[LAT];

endmodule

// File: tb/tb_pipe_addsub_acc.sv
// tb/tb_pipe_addsub_acc.sv - self-checking bench for pipe_addsub_acc
module tb_pipe_addsub_acc;
  import addsub_pkg::*;

  localparam int W = 7;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b;
  logic [1:0]   in_mode;
  logic [W:0]   out;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  pipe_addsub_acc #(.WIDTH(W), .LAT(L)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  typedef struct {
    logic [1:0] mode;
    int         a;
    int         b;
    int         exp;
  } vec_t;

  typedef struct {
    longint res;
    int     cyc;
    bit     timed;
  } beat_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [1:0] m, input int a, input int b, input int e);
    vec_t v;
    v.mode = m; v.a = a; v.b = b; v.exp = e;
    vecs.push_back(v);
  endtask

  // WIDTH=16 sweeps at LAT=1 and LAT=4, each with its own stimulus and model.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int SL = (g == 0) ? 1 : 4;
    localparam int SW = 16;
    logic          s_rst_n, s_iv, s_ir, s_ov, s_or;
    logic [SW-1:0] s_a, s_b;
    logic [1:0]    s_m;
    logic [SW:0]   s_out;
    logic          done;

    pipe_addsub_acc #(.WIDTH(SW), .LAT(SL)) u_sdut (
      .clk(clk), .rst_n(s_rst_n), .in_valid(s_iv), .in_ready(s_ir),
      .in_a(s_a), .in_b(s_b), .in_mode(s_m),
      .out_valid(s_ov), .out_ready(s_or), .out(s_out)
    );

    initial begin
      beat_t  q[$];
      beat_t  bt;
      longint acc, res, a, b, modulus;
      int     r;
      bit     unstalled;
      modulus = 64'd1 << (SW + 1);
      acc = 0;
      done = 1'b0;
      s_rst_n = 1'b0; s_iv = 1'b0; s_or = 1'b0; s_a = '0; s_b = '0; s_m = MODE_ADD;
      repeat (2) @(negedge clk);
      s_rst_n = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 400; cyc++) begin
        unstalled = (cyc >= 250) && (cyc < 350);
        s_iv = (cyc < 350) ? ($urandom_range(0, 3) != 0) : 1'b0;
        s_or = (cyc >= 250) ? 1'b1 : ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 7);
        s_m = (r < 2) ? MODE_ADD : (r < 4) ? MODE_SUB : (r < 7) ? MODE_ACC : MODE_CLR;
        s_a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        s_b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        if (cyc == 0) begin
          s_iv = 1'b1; s_m = MODE_ADD; s_a = 16'hFFFF; s_b = 16'hFFFF;
        end
        #1;
        check("sw_in_ready", s_ir, !s_ov || s_or);
        if (s_ov) begin
          check("sw_expected_beat", q.size() > 0, 1);
          if (q.size() > 0) begin
            check("sw_out", s_out, q[0].res);
            if (s_or) begin
              if (q[0].cyc == 0) check("sw_max_add", s_out, 131070);
              if (q[0].timed) check("sw_latency", cyc - q[0].cyc, SL);
              void'(q.pop_front());
            end
          end
        end
        if (s_iv && s_ir) begin
          a = longint'(s_a);
          b = longint'(s_b);
          case (s_m)
            MODE_ADD: res = a + b;
            MODE_SUB: res = (a - b + modulus) % modulus;
            MODE_ACC: begin acc = (acc + a + b) % modulus; res = acc; end
            default:  begin acc = 0; res = 0; end
          endcase
          bt.res = res; bt.cyc = cyc; bt.timed = unstalled;
          q.push_back(bt);
        end
        @(negedge clk);
      end
      check("sw_drained", q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int          res_q[$];
    int          sent, cyc;
    logic [W:0]  prev_out;
    bit          prev_stall;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = MODE_ADD; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 0);
    check("rst_in_ready", in_ready, 1);

    add_vec(MODE_ADD, 127, 127, 254);
    add_vec(MODE_ADD, 3, 4, 7);
    add_vec(MODE_SUB, 5, 9, 252);
    add_vec(MODE_SUB, 9, 5, 4);
    add_vec(MODE_SUB, 0, 127, 129);
    add_vec(MODE_SUB, 127, 127, 0);
    add_vec(MODE_CLR, 55, 66, 0);
    add_vec(MODE_ACC, 10, 20, 30);
    add_vec(MODE_ACC, 100, 0, 130);
    add_vec(MODE_ADD, 1, 1, 2);
    add_vec(MODE_ACC, 0, 1, 131);
    add_vec(MODE_CLR, 0, 0, 0);
    add_vec(MODE_ACC, 127, 127, 254);
    add_vec(MODE_ACC, 1, 0, 255);
    add_vec(MODE_ACC, 1, 0, 0);
    add_vec(MODE_ACC, 3, 4, 7);

    for (int i = 0; i < vecs.size() + L; i++) begin
      if (i >= L) begin
        check($sformatf("vec%0d_valid", i - L), out_valid, 1);
        check($sformatf("vec%0d_out", i - L), out, vecs[i-L].exp);
      end
      if (i < vecs.size()) begin
        in_valid = 1'b1;
        in_mode  = vecs[i].mode;
        in_a     = W'(vecs[i].a);
        in_b     = W'(vecs[i].b);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("vec_tail_bubble", out_valid, 0);

    sent = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    while (res_q.size() < 6 && cyc < 60) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 6);
      in_mode   = MODE_ADD;
      in_a      = W'(sent * 10);
      in_b      = W'(sent);
      #1;
      check("bp_in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) check("bp_hold", out, prev_out);
      if (out_valid && out_ready) res_q.push_back(int'(out));
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_out   = out;
      cyc++;
      @(negedge clk);
    end
    check("bp_count", res_q.size(), 6);
    for (int i = 0; i < res_q.size(); i++) check($sformatf("bp_res%0d", i), res_q[i], 11 * i);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);

    in_valid = 1'b1; in_mode = MODE_CLR; in_a = '0; in_b = '0;
    @(negedge clk);
    in_mode = MODE_ACC; in_a = 7'd50; in_b = '0;
    @(negedge clk);
    in_mode = MODE_ADD; in_a = 7'd1; in_b = 7'd1;
    @(negedge clk);
    in_a = 7'd2; in_b = 7'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_out", out, 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out", out, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_mode = MODE_ACC; in_a = 7'd1; in_b = '0;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_rst_bubble", out_valid, 0);
    @(negedge clk);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_acc", out, 1);

    for (int c = 0; c < 2000 && !(g_sweep[0].done && g_sweep[1].done); c++) @(negedge clk);
    check("sweep_done", g_sweep[0].done && g_sweep[1].done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
